bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
- Parametrised multi-digit decimal counter driven from the board clock through an internal prescaler.
- Generalises the single-digit 0-9 seconds counter:
  - configurable digit count, terminal value and tick rate;
  - up/down mode, count enable and synchronous load;
  - optional leading-zero blanking.
- Drives the HEX displays directly (active-low seven-segment).
- Exports BCD digits, a tick strobe and a wrap strobe for cascading into minute/hour stages.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ, integer, >= 2.
- DIGITS, 4, number of BCD digits (1..8).
- MAX_COUNT, 9999, terminal decimal value. Must satisfy MAX_COUNT < 10**DIGITS. Converted to BCD at elaboration.
- BLANK_LZ, 0, 1 = blank leading zero digits on HEX (digit 0 never blanked).

Ports:
- CLOCK_50  in   1            system clock, all logic on posedge.
- Clr       in   1            asynchronous active-low reset.
- En        in   1            1 = prescaler and counter run; 0 = both frozen.
- Up        in   1            1 = count up, 0 = count down. Sampled at each tick.
- Load      in   1            synchronous load strobe.
- LoadVal   in   4*DIGITS     BCD load value, digit i at [4i+3:4i].
- Q         out  4*DIGITS     current BCD value, registered.
- HEX       out  7*DIGITS     active-low segments. Digit i at [7i+6:7i], bit 7i = seg a ... bit 7i+6 = seg g.
- Tick      out  1            one-cycle strobe per prescaler rollover.
- Wrap      out  1            one-cycle strobe when the counter wraps.

Behaviour:
- Reset (Clr=0, asynchronous):
  - prescaler=0, Q=0, Tick=0, Wrap=0.
  - HEX shows "0" on digit 0. Other digits show "0" if BLANK_LZ=0, blank (all 1s) if BLANK_LZ=1.
  - Release is synchronous to the next posedge. First tick occurs DIV cycles after release with En=1.
- Prescaler:
  - Counts 0..DIV-1 while En=1 and Load=0.
  - At value DIV-1 it returns to 0 and the counter steps on that same edge.
  - Tick is registered and high for exactly the cycle after that edge.
  - Period is exactly DIV cycles; no drift.
- Count step, up (Up=1):
  - Digit 0 increments. A digit at 9 becomes 0 and carries to the next digit.
  - If Q == MAX_COUNT (BCD compare), Q becomes 0 and Wrap pulses.
- Count step, down (Up=0):
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - If Q == 0, Q becomes MAX_COUNT and Wrap pulses.
- Wrap is registered and coincident with Tick (same cycle). It never asserts without Tick.
- Load (priority over counting):
  - Load=1 sets Q=LoadVal and prescaler=0 on the next edge; no tick and no wrap in that cycle.
  - Sanitisation: any digit > 9, or a value > MAX_COUNT, loads MAX_COUNT instead.
  - Load acts regardless of En.
- En=0:
  - Prescaler and Q hold; Tick=Wrap=0.
  - On resuming, the prescaler continues from its held value; no restart.
- Up change between ticks has no effect until the next tick. An Up change coinciding with the rollover edge uses the sampled value on that edge.
- Decoder:
  - Combinational from registered Q; no added latency; glitch-free relative to Q.
  - Patterns (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Blanking (BLANK_LZ=1):
  - Digit i (i>0) is blanked when it and all higher digits are 0.
  - Q is unaffected by blanking.
- Invariant: Q is always valid BCD and <= MAX_COUNT.

Test Plan:
1. Reset and rate. CLK_HZ=10, TICK_HZ=1, DIGITS=2, MAX_COUNT=59, En=1, Up=1. Release Clr:
   - Tick first at cycle 10, then every 10 cycles.
   - Q reads 00,01,...,09,10; digit 1 increments on the 09->10 transition.
2. Up wrap. Load 58:
   - 2 ticks later Q=00 and Wrap=1 together with Tick, one cycle only.
   - Clr pulsed low mid-prescale: Q=00, Tick=0 immediately, without waiting for a clock edge.
3. Down and borrow. Up=0 from Q=10 -> 09, then from 00 -> 59 with Wrap=1. With DIGITS=4 and MAX_COUNT=9999, Q=1000 down -> 0999.
4. Load and sanitisation:
   - Load 0x3A (digit 0 = A) -> Q=59.
   - Load 0x71 (71 > 59) -> Q=59.
   - Load 0x25 -> Q=25, prescaler restarts, next Tick exactly 10 cycles later.
   - Load asserted with En=0 -> still loads.
5. Enable freeze. Drop En at prescaler=6 for 20 cycles:
   - Q unchanged, no Tick.
   - After En=1, next Tick arrives 4 cycles later.
6. Display and blanking. BLANK_LZ=1, DIGITS=4:
   - Q=0007 -> HEX digits 3..1 = 1111111, digit 0 = 0001111.
   - Q=0000 -> only digit 0 lit (0000001).
   - Q=1002 -> all digits lit.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler,
// with sanitised load and active-low seven-segment outputs.
module bcd_tick_counter #(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 1,
   parameter int DIGITS    = 4,
   parameter int MAX_COUNT = 9999,
   parameter int BLANK_LZ  = 0
) (
   input  logic                  CLOCK_50,
   input  logic                  Clr,
   input  logic                  En,
   input  logic                  Up,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   LoadVal,
   output logic [4*DIGITS-1:0]   Q,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  Tick,
   output logic                  Wrap
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int W   = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(int v);
      logic [W-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // segment order in the returned vector is {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7(logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   localparam logic [W-1:0]  MAX_BCD = to_bcd(MAX_COUNT);
   localparam logic [PW-1:0] LAST    = PW'(DIV - 1);

   logic [PW-1:0] presc;
   logic [W-1:0]  inc_q;
   logic [W-1:0]  dec_q;
   logic [W-1:0]  step_q;
   logic [W-1:0]  ld_q;
   logic          carry;
   logic          borrow;
   logic          ld_bad;
   logic          wrap_n;
   logic          seen;
   logic          blank;

   always_comb begin
      inc_q  = Q;
      dec_q  = Q;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (Q[4*i +: 4] == 4'd9) begin
               inc_q[4*i +: 4] = 4'd0;
            end else begin
               inc_q[4*i +: 4] = Q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (Q[4*i +: 4] == 4'd0) begin
               dec_q[4*i +: 4] = 4'd9;
            end else begin
               dec_q[4*i +: 4] = Q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      if (Up) begin
         wrap_n = (Q == MAX_BCD);
         step_q = wrap_n ? '0 : inc_q;
      end else begin
         wrap_n = (Q == '0);
         step_q = wrap_n ? MAX_BCD : dec_q;
      end
   end

   // valid BCD orders the same as its packed binary value
   always_comb begin
      ld_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (LoadVal[4*i +: 4] > 4'd9) ld_bad = 1'b1;
      end
      if (LoadVal > MAX_BCD) ld_bad = 1'b1;
      ld_q = ld_bad ? MAX_BCD : LoadVal;
   end

   always_ff @(posedge CLOCK_50 or negedge Clr) begin
      if (!Clr) begin
         presc <= '0;
         Q     <= '0;
         Tick  <= 1'b0;
         Wrap  <= 1'b0;
      end else if (Load) begin
         presc <= '0;
         Q     <= ld_q;
         Tick  <= 1'b0;
         Wrap  <= 1'b0;
      end else if (En) begin
         if (presc == LAST) begin
            presc <= '0;
            Q     <= step_q;
            Tick  <= 1'b1;
            Wrap  <= wrap_n;
         end else begin
            presc <= presc + 1'b1;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
         end
      end else begin
         Tick <= 1'b0;
         Wrap <= 1'b0;
      end
   end

   always_comb begin
      HEX   = '1;
      seen  = 1'b0;
      blank = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen  = seen | (Q[4*i +: 4] != 4'd0);
         blank = (BLANK_LZ != 0) && (i != 0) && !seen;
         HEX[7*i +: 7] = blank ? 7'h7F : seg7(Q[4*i +: 4]);
      end
   end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: two instances (2-digit/59, 4-digit/9999
// blanked) checked each cycle against an integer reference model.
module tb_bcd_tick_counter;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        clr;
   logic        en [2];
   logic        up [2];
   logic        ld [2];
   logic [15:0] lv [2];

   logic [7:0]  q0;
   logic [13:0] hex0;
   logic        tick0, wrap0;
   logic [15:0] q1;
   logic [27:0] hex1;
   logic        tick1, wrap1;

   int checks = 0;
   int errors = 0;

   int cnt [2];
   int pre [2];
   bit tk  [2];
   bit wr  [2];
   int mx  [2] = '{59, 9999};
   int nd  [2] = '{2, 4};
   bit bl  [2] = '{1'b0, 1'b1};

   // a..g as written left to right
   logic [6:0] pat [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   always #5 clk = ~clk;

   bcd_tick_counter #(
      .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2),
      .MAX_COUNT(59), .BLANK_LZ(0)
   ) u_a (
      .CLOCK_50(clk), .Clr(clr), .En(en[0]), .Up(up[0]),
      .Load(ld[0]), .LoadVal(lv[0][7:0]), .Q(q0), .HEX(hex0),
      .Tick(tick0), .Wrap(wrap0)
   );

   bcd_tick_counter #(
      .CLK_HZ(10), .TICK_HZ(1), .DIGITS(4),
      .MAX_COUNT(9999), .BLANK_LZ(1)
   ) u_b (
      .CLOCK_50(clk), .Clr(clr), .En(en[1]), .Up(up[1]),
      .Load(ld[1]), .LoadVal(lv[1]), .Q(q1), .HEX(hex1),
      .Tick(tick1), .Wrap(wrap1)
   );

   task automatic check(string tag, logic [31:0] got,
                        logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bcd(int v, int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++)
         r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      return r;
   endfunction

   function automatic logic [31:0] exp_hex(int v, int n, bit b);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) begin
         int p = 10 ** i;
         int d = (v / p) % 10;
         if (b && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
         else for (int s = 0; s < 7; s++) r[7*i+s] = pat[d][6-s];
      end
      return r;
   endfunction

   function automatic int sanit(logic [15:0] raw, int n, int m);
      int v = 0;
      for (int i = n - 1; i >= 0; i--) begin
         int d = int'(raw[4*i +: 4]);
         if (d > 9) return m;
         v = v * 10 + d;
      end
      return (v > m) ? m : v;
   endfunction

   task automatic model(int k);
      if (!clr) begin
         cnt[k] = 0; pre[k] = 0; tk[k] = 0; wr[k] = 0;
      end else if (ld[k]) begin
         cnt[k] = sanit(lv[k], nd[k], mx[k]);
         pre[k] = 0; tk[k] = 0; wr[k] = 0;
      end else if (en[k]) begin
         if (pre[k] == DIV - 1) begin
            pre[k] = 0;
            tk[k]  = 1;
            if (up[k]) begin
               wr[k]  = (cnt[k] == mx[k]);
               cnt[k] = wr[k] ? 0 : cnt[k] + 1;
            end else begin
               wr[k]  = (cnt[k] == 0);
               cnt[k] = wr[k] ? mx[k] : cnt[k] - 1;
            end
         end else begin
            pre[k]++; tk[k] = 0; wr[k] = 0;
         end
      end else begin
         tk[k] = 0; wr[k] = 0;
      end
   endtask

   task automatic compare();
      check("q_a", 32'(q0), bcd(cnt[0], 2));
      check("tick_a", 32'(tick0), 32'(tk[0]));
      check("wrap_a", 32'(wrap0), 32'(wr[0]));
      check("hex_a", 32'(hex0), exp_hex(cnt[0], 2, bl[0]));
      check("q_b", 32'(q1), bcd(cnt[1], 4));
      check("tick_b", 32'(tick1), 32'(tk[1]));
      check("wrap_b", 32'(wrap1), 32'(wr[1]));
      check("hex_b", 32'(hex1), exp_hex(cnt[1], 4, bl[1]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model(0);
      model(1);
      #1;
      compare();
   endtask

   task automatic load(int k, logic [15:0] v);
      ld[k] = 1'b1;
      lv[k] = v;
      cyc();
      ld[k] = 1'b0;
   endtask

   task automatic wait_tick(int k, output int n);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         n++;
         if ((k == 0) ? tick0 : tick1) break;
      end
   endtask

   initial begin
      int n;
      clr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; up[k] = 1'b1; ld[k] = 1'b0; lv[k] = '0;
         cnt[k] = 0; pre[k] = 0; tk[k] = 0; wr[k] = 0;
      end
      repeat (3) cyc();
      check("rst_q_a", 32'(q0), 32'h0);
      check("rst_hex_b", 32'(hex1), {4'h0, 21'h1FFFFF, 7'b1000000});

      en[0] = 1'b1;
      clr   = 1'b1;
      wait_tick(0, n);
      check("first_tick", n, 10);
      for (int t = 0; t < 9; t++) begin
         wait_tick(0, n);
         check("tick_period", n, 10);
      end
      check("q_ten", 32'(q0), 32'h10);

      load(0, 16'h58);
      wait_tick(0, n);
      check("q_59", 32'(q0), 32'h59);
      wait_tick(0, n);
      check("wrap_q", 32'(q0), 32'h00);
      check("wrap_hi", 32'(wrap0), 32'h1);
      cyc();
      check("wrap_lo", 32'(wrap0), 32'h0);
      wait_tick(0, n);
      #3 clr = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; pre[k] = 0; tk[k] = 0; wr[k] = 0;
      end
      check("aclr_q", 32'(q0), 32'h0);
      check("aclr_tick", 32'(tick0), 32'h0);
      cyc();
      clr = 1'b1;

      up[0] = 1'b0;
      load(0, 16'h10);
      wait_tick(0, n);
      check("down_09", 32'(q0), 32'h09);
      load(0, 16'h00);
      wait_tick(0, n);
      check("down_59", 32'(q0), 32'h59);
      check("down_wrap", 32'(wrap0), 32'h1);
      en[1] = 1'b1;
      up[1] = 1'b0;
      load(1, 16'h1000);
      wait_tick(1, n);
      check("borrow_b", 32'(q1), 32'h0999);

      up[0] = 1'b1;
      load(0, 16'h3A);
      check("ld_3a", 32'(q0), 32'h59);
      load(0, 16'h71);
      check("ld_71", 32'(q0), 32'h59);
      repeat (3) cyc();
      load(0, 16'h25);
      check("ld_25", 32'(q0), 32'h25);
      wait_tick(0, n);
      check("ld_restart", n, 10);
      en[0] = 1'b0;
      load(0, 16'h33);
      check("ld_noen", 32'(q0), 32'h33);
      en[0] = 1'b1;

      for (int c = 0; c < 20 && pre[0] != 6; c++) cyc();
      en[0] = 1'b0;
      repeat (20) cyc();
      check("frz_q", 32'(q0), 32'h33);
      en[0] = 1'b1;
      wait_tick(0, n);
      check("frz_resume", n, 4);

      en[1] = 1'b0;
      load(1, 16'h0007);
      check("hex_0007", 32'(hex1),
            {4'h0, 21'h1FFFFF, 7'b1111000});
      load(1, 16'h0000);
      check("hex_0000", 32'(hex1),
            {4'h0, 21'h1FFFFF, 7'b1000000});
      load(1, 16'h1002);
      check("hex_1002", 32'(hex1),
            {4'h0, 7'b1111001, 7'b1000000, 7'b1000000, 7'b0100100});

      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 2; k++) begin
            en[k] = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) up[k] = ~up[k];
            ld[k] = ($urandom_range(49) == 0);
            if ($urandom_range(1) == 0)
               lv[k] = 16'($urandom);
            else
               lv[k] = 16'(bcd($urandom_range(mx[k]), 4));
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
